// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit processor pipeline (decode, writeback and
// the register file). Holds the data/address widths, the register count, the
// word and register-address types, and the hardwired-zero register index.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int ADDR_W = 3;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_addr_t REG_ZERO = 3'd0;

   // True when a valid writeback targets register a this cycle.
   function automatic logic wb_hits(input logic      wb_en,
                                    input reg_addr_t wb_addr,
                                    input reg_addr_t a);
      return wb_en && (wb_addr == a);
   endfunction

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// scoreboard
// Tracks destinations reserved by issued instructions and still waiting for
// their writeback. Produces the combinational issue-ready signal for decode
// and a sticky flag for writebacks that hit a register nobody reserved.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   wb_en, wb_addr          writeback valid / destination
//   rd_valid                decode presents an instruction
//   rs1_addr, rs2_addr      source registers of that instruction
//   dest_en, dest_addr      destination the instruction wants to reserve
//   rd_ready                no RAW/WAW hazard this cycle
//   pending                 reservation bits (bit 0 always 0)
//   wb_err                  sticky unexpected-writeback flag
// -----------------------------------------------------------------------------
module scoreboard
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic              dest_en,
   input  logic [ADDR_W-1:0] dest_addr,
   output logic              rd_ready,
   output logic [NREG-1:0]   pending,
   output logic              wb_err
);

   logic [NREG-1:0] pending_q, pending_d;
   logic            wb_err_q, wb_err_d;
   logic            blk1_s, blk2_s, blk_dest_s, accept_s;

   // Hazard detection; a writeback landing this cycle releases its register
   // immediately because the operand bypass covers it.
   always_comb begin
      blk1_s     = (rs1_addr != REG_ZERO) && pending_q[rs1_addr]
                   && !wb_hits(wb_en, wb_addr, rs1_addr);
      blk2_s     = (rs2_addr != REG_ZERO) && pending_q[rs2_addr]
                   && !wb_hits(wb_en, wb_addr, rs2_addr);
      blk_dest_s = dest_en && (dest_addr != REG_ZERO) && pending_q[dest_addr]
                   && !wb_hits(wb_en, wb_addr, dest_addr);
      rd_ready   = !blk1_s && !blk2_s && !blk_dest_s;
      accept_s   = rd_valid && rd_ready;
   end

   // Next reservation state: writeback clears first, a new reservation then
   // sets, so a same-cycle set on the same register wins.
   always_comb begin
      pending_d = pending_q;
      wb_err_d  = wb_err_q;
      if (wb_en && (wb_addr != REG_ZERO)) begin
         if (!pending_q[wb_addr]) begin
            wb_err_d = 1'b1;
         end else begin
            wb_err_d = wb_err_q;
         end
         pending_d[wb_addr] = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (accept_s && dest_en && (dest_addr != REG_ZERO)) begin
         pending_d[dest_addr] = 1'b1;
      end else begin
         wb_err_d = wb_err_d;
      end
      pending_d[0] = 1'b0;
   end

   // Scoreboard state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= {NREG{1'b0}};
         wb_err_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         wb_err_q  <= wb_err_d;
      end
   end

   assign pending = pending_q;
   assign wb_err  = wb_err_q;

endmodule

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// Eight-entry 16-bit register file at the end of the writeback stage. Commits
// writebacks (R0 hardwired to zero), serves two registered operand-read ports
// to decode with same-cycle writeback bypass, and stalls decode through the
// scoreboard until pending destinations are written back.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   wb_en, wb_addr, ans_wb        writeback valid / destination / data
//   rd_valid                      decode presents an instruction
//   rs1_addr, rs2_addr            source registers
//   dest_en, dest_addr            destination to reserve on issue
//   rd_ready                      issue accepted when rd_valid && rd_ready
//   rs1_data, rs2_data            registered operands
//   op_valid                      one-cycle pulse, operands valid
//   pending                       scoreboard bits
//   wb_err                        sticky unexpected-writeback flag
// -----------------------------------------------------------------------------
module regfile_wb
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] ans_wb,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic              dest_en,
   input  logic [ADDR_W-1:0] dest_addr,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic              op_valid,
   output logic [NREG-1:0]   pending,
   output logic              wb_err
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] rs1_val_s, rs2_val_s;
   logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic              op_valid_q, op_valid_d;
   logic              rd_ready_s, accept_s;

   scoreboard u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .rd_valid  (rd_valid),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .dest_en   (dest_en),
      .dest_addr (dest_addr),
      .rd_ready  (rd_ready_s),
      .pending   (pending),
      .wb_err    (wb_err)
   );

   assign accept_s = rd_valid && rd_ready_s;

   // Operand selection: bypass the in-flight writeback, force R0 to zero.
   always_comb begin
      if (wb_hits(wb_en, wb_addr, rs1_addr) && (rs1_addr != REG_ZERO)) begin
         rs1_val_s = ans_wb;
      end else if (rs1_addr == REG_ZERO) begin
         rs1_val_s = {DATA_W{1'b0}};
      end else begin
         rs1_val_s = regs_q[rs1_addr];
      end
      if (wb_hits(wb_en, wb_addr, rs2_addr) && (rs2_addr != REG_ZERO)) begin
         rs2_val_s = ans_wb;
      end else if (rs2_addr == REG_ZERO) begin
         rs2_val_s = {DATA_W{1'b0}};
      end else begin
         rs2_val_s = regs_q[rs2_addr];
      end
   end

   // Operand registers load only on accept and hold otherwise.
   always_comb begin
      op_valid_d = accept_s;
      if (accept_s) begin
         rs1_data_d = rs1_val_s;
         rs2_data_d = rs2_val_s;
      end else begin
         rs1_data_d = rs1_data_q;
         rs2_data_d = rs2_data_q;
      end
   end

   // Register storage; writes to R0 are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_en && (wb_addr != REG_ZERO)) begin
         regs_q[wb_addr] <= ans_wb;
      end
   end

   // Operand output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs1_data_q <= {DATA_W{1'b0}};
         rs2_data_q <= {DATA_W{1'b0}};
         op_valid_q <= 1'b0;
      end else begin
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign rd_ready = rd_ready_s;
   assign rs1_data = rs1_data_q;
   assign rs2_data = rs2_data_q;
   assign op_valid = op_valid_q;

endmodule

// File: tb/tb_regfile_wb.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb
// Directed bench for regfile_wb with a behavioural register/scoreboard model
// checked against the DUT on every falling edge, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] ans_wb;
   logic        rd_valid;
   logic [2:0]  rs1_addr, rs2_addr;
   logic        dest_en;
   logic [2:0]  dest_addr;
   logic        rd_ready;
   logic [15:0] rs1_data, rs2_data;
   logic        op_valid;
   logic [7:0]  pending;
   logic        wb_err;

   int tests = 0;
   int fails = 0;

   regfile_wb dut (
      .clk       (clk),
      .reset     (reset),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .ans_wb    (ans_wb),
      .rd_valid  (rd_valid),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .dest_en   (dest_en),
      .dest_addr (dest_addr),
      .rd_ready  (rd_ready),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .op_valid  (op_valid),
      .pending   (pending),
      .wb_err    (wb_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_regs [8];
   logic [7:0]  m_pend;
   logic        m_err, m_opv;
   logic [15:0] m_d1, m_d2;

   task automatic m_clear();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_pend = 8'h00;
      m_err  = 1'b0;
      m_opv  = 1'b0;
      m_d1   = 16'h0000;
      m_d2   = 16'h0000;
   endtask

   // Register is still owed a writeback that is not arriving right now.
   function automatic logic m_waiting(input logic [2:0] a);
      return (a != 3'd0) && m_pend[a] && !(wb_en && wb_addr == a);
   endfunction

   function automatic logic m_ready();
      logic r;
      r = 1'b1;
      if (m_waiting(rs1_addr)) r = 1'b0;
      if (m_waiting(rs2_addr)) r = 1'b0;
      if (dest_en && m_waiting(dest_addr)) r = 1'b0;
      return r;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a);
      if (a == 3'd0) return 16'h0000;
      if (wb_en && wb_addr == a) return ans_wb;
      return m_regs[a];
   endfunction

   initial begin
      logic        acc;
      logic [15:0] v1, v2;
      m_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_clear();
         end else begin
            acc = rd_valid && m_ready();
            v1  = m_read(rs1_addr);
            v2  = m_read(rs2_addr);
            m_opv = acc;
            if (acc) begin
               m_d1 = v1;
               m_d2 = v2;
            end
            if (wb_en && wb_addr != 3'd0) begin
               if (!m_pend[wb_addr]) m_err = 1'b1;
               m_regs[wb_addr] = ans_wb;
               m_pend[wb_addr] = 1'b0;
            end
            if (acc && dest_en && dest_addr != 3'd0) m_pend[dest_addr] = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("cmp_rd_ready", 32'(rd_ready), 32'(m_ready()));
         chk("cmp_pending",  32'(pending),  32'(m_pend));
         chk("cmp_wb_err",   32'(wb_err),   32'(m_err));
         chk("cmp_op_valid", 32'(op_valid), 32'(m_opv));
         chk("cmp_rs1_data", 32'(rs1_data), 32'(m_d1));
         chk("cmp_rs2_data", 32'(rs2_data), 32'(m_d2));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set(input logic rv, input logic [2:0] r1, input logic [2:0] r2,
                      input logic de, input logic [2:0] da,
                      input logic we, input logic [2:0] wa, input logic [15:0] ans);
      rd_valid  = rv;
      rs1_addr  = r1;
      rs2_addr  = r2;
      dest_en   = de;
      dest_addr = da;
      wb_en     = we;
      wb_addr   = wa;
      ans_wb    = ans;
   endtask

   task automatic idle();
      set(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_ready", 32'(rd_ready), 32'd1);
      chk("rst_pending",  32'(pending),  32'd0);
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_rs1_data", 32'(rs1_data), 32'd0);
      chk("rst_rs2_data", 32'(rs2_data), 32'd0);
      chk("rst_wb_err",   32'(wb_err),   32'd0);
      reset = 1'b1;
      tick();

      // Reset then read
      set(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      #1 chk("read_ready", 32'(rd_ready), 32'd1);
      tick(); idle(); #1;
      chk("read_op_valid", 32'(op_valid), 32'd1);
      chk("read_rs1", 32'(rs1_data), 32'h0000);
      chk("read_rs2", 32'(rs2_data), 32'h0000);
      tick();

      // Reserve and stall
      set(1'b1, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0000);
      tick();
      set(1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      #1;
      chk("stall_ready", 32'(rd_ready), 32'd0);
      chk("stall_pending", 32'(pending), 32'h20);
      tick(); tick();
      chk("stall_no_op", 32'(op_valid), 32'd0);
      set(1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 16'h0005);
      #1 chk("wb_release_ready", 32'(rd_ready), 32'd1);
      tick(); idle(); #1;
      chk("wb_release_rs1", 32'(rs1_data), 32'h0005);
      chk("wb_release_pending", 32'(pending), 32'h00);
      tick();

      // Bypass and R0
      set(1'b1, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0000);
      tick();
      set(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0008);
      #1 chk("bypass_ready", 32'(rd_ready), 32'd1);
      tick(); idle(); #1;
      chk("bypass_rs1", 32'(rs1_data), 32'h0008);
      chk("bypass_rs2", 32'(rs2_data), 32'h0008);
      set(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 16'h0003);
      tick();
      set(1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      tick(); idle(); #1;
      chk("r0_read", 32'(rs1_data), 32'h0000);
      chk("r2_read", 32'(rs2_data), 32'h0008);
      chk("r0_no_err", 32'(wb_err), 32'd0);

      // WAW and set-wins
      set(1'b1, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
      tick();
      set(1'b1, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
      #1 chk("waw_stall", 32'(rd_ready), 32'd0);
      tick();
      set(1'b1, 3'd0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd4, 16'h0044);
      #1 chk("waw_release", 32'(rd_ready), 32'd1);
      tick(); idle(); #1;
      chk("set_wins", 32'(pending), 32'h10);
      set(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h0045);
      tick(); idle(); #1;
      chk("waw_cleared", 32'(pending), 32'h00);
      chk("waw_no_err", 32'(wb_err), 32'd0);

      // Unexpected writeback
      set(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd6, 16'h0002);
      tick(); idle(); #1;
      chk("unexp_err", 32'(wb_err), 32'd1);
      set(1'b1, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      tick(); idle(); #1;
      chk("unexp_data", 32'(rs1_data), 32'h0002);
      tick(); tick();
      chk("err_sticky", 32'(wb_err), 32'd1);

      // Self-dependency, back-to-back, then async reset mid-operation
      set(1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0000);
      #1 chk("selfdep_ready", 32'(rd_ready), 32'd1);
      tick();
      set(1'b1, 3'd4, 3'd4, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
      #1 chk("selfdep_old_val", 32'(rs1_data), 32'h0008);
      tick(); idle(); #1;
      chk("b2b_pending", 32'(pending), 32'h14);
      chk("b2b_op_valid", 32'(op_valid), 32'd1);
      chk("b2b_rs1", 32'(rs1_data), 32'h0045);
      reset = 1'b0;
      #1;
      chk("async_pending",  32'(pending),  32'd0);
      chk("async_op_valid", 32'(op_valid), 32'd0);
      chk("async_rs1",      32'(rs1_data), 32'd0);
      chk("async_rs2",      32'(rs2_data), 32'd0);
      chk("async_wb_err",   32'(wb_err),   32'd0);
      chk("async_rd_ready", 32'(rd_ready), 32'd1);
      reset = 1'b1;
      set(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h0099);
      tick(); idle(); #1;
      chk("flush_late_wb_err", 32'(wb_err), 32'd1);

      // Mixed traffic checked by the per-cycle model comparison
      for (int i = 0; i < 200; i++) begin
         set(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom));
         tick();
      end
      idle();
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
